// File: rtl/bigsdiv.sv
// bigsdiv: multi-cycle 32-bit signed/unsigned restoring divider.
// One quotient bit per clock, a separate cycle for sign fix-up, and C-style
// truncating results (quotient toward zero, remainder takes the dividend's sign).
// A zero divisor completes on the next cycle with o_err set.
module bigsdiv (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr,
  input  logic        i_sgn,
  input  logic [31:0] i_numerator,
  input  logic [31:0] i_denominator,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_err,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [31:0] num_q;    // dividend shifts out of the top, quotient shifts in at the bottom
  logic [31:0] den;
  logic [31:0] partial;
  logic        neg_q, neg_r;
  logic [32:0] trial;
  logic        accept, div_zero;

  // Two's-complement magnitude, only in signed mode.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  // A request is taken only in IDLE with busy low; busy stays high through the
  // o_valid cycle, so a request coinciding with o_valid is dropped.
  assign accept   = i_wr && !o_busy && (state == IDLE);
  assign div_zero = (i_denominator == 32'd0);

  // Restoring step: 33-bit trial subtract; a clear sign bit means D fits.
  assign trial = {partial, num_q[31]} - {1'b0, den};

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !div_zero) state_nxt = DIVIDE;
      DIVIDE:  if (count == 5'd0)       state_nxt = FIXUP;
      FIXUP:                            state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
      o_quotient  <= 32'd0;
      o_remainder <= 32'd0;
      count       <= 5'd0;
      num_q       <= 32'd0;
      den         <= 32'd0;
      partial     <= 32'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && div_zero) begin
            // Divide by zero: report immediately, dividend passed through raw.
            o_valid     <= 1'b1;
            o_err       <= 1'b1;
            o_quotient  <= 32'd0;
            o_remainder <= i_numerator;
          end else if (accept) begin
            num_q   <= mag(i_numerator, i_sgn);
            den     <= mag(i_denominator, i_sgn);
            neg_q   <= i_sgn & (i_numerator[31] ^ i_denominator[31]);
            neg_r   <= i_sgn & i_numerator[31];
            partial <= 32'd0;
            count   <= 5'd31;
            o_busy  <= 1'b1;
          end else begin
            // Also the cycle after FIXUP: busy drops here, one cycle after o_valid rises.
            o_busy <= 1'b0;
          end
        end
        DIVIDE: begin
          if (!trial[32]) partial <= trial[31:0];
          else            partial <= {partial[30:0], num_q[31]};
          num_q <= {num_q[30:0], ~trial[32]};
          if (count != 5'd0) count <= count - 5'd1;
        end
        FIXUP: begin
          // Negation gets its own cycle to keep it off the subtract path.
          o_quotient  <= neg_q ? (32'd0 - num_q)   : num_q;
          o_remainder <= neg_r ? (32'd0 - partial) : partial;
          o_valid     <= 1'b1;
          o_err       <= 1'b0;
        end
        default: o_busy <= 1'b0;
      endcase
    end
  end

endmodule
